case_2_mul_share_arb: RTL

- Time-shares one signed multiplier (A_W-bit x B_W-bit, product truncated to P_W bits) among N requesters.
- Round-robin arbitration; each requester has a valid/ready operand port.
- One registered result port with valid/ready backpressure, tagged with the requester index.
- Sits between HLS-generated loop bodies that each need an occasional multiply. The team uses it to cut multiplier count when initiation-interval slack allows.

---
 rtl/case_2_mul_share_arb_if.sv | 35 +++
 rtl/case_2_mul_share_arb.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/case_2_mul_share_arb_if.sv
// case_2_mul_share_arb_if
// Bundles the operand and result handshakes of the shared multiplier.
//   req_vld/req_rdy : per-requester operand handshake (N bits each)
//   req_a / req_b   : packed signed operands, requester i at [i*W +: W]
//   res_vld/res_rdy : result handshake
//   res_dout        : signed product, res_id : producing requester
//   res_sat         : product was clamped (saturating build only)
// Modports: master = requesters + result consumer, slave = arbiter.
interface case_2_mul_share_arb_if #(
  parameter int N    = 4,
  parameter int A_W  = 5,
  parameter int B_W  = 4,
  parameter int P_W  = 5,
  parameter int ID_W = 2
);
  logic [N-1:0]     req_vld;
  logic [N-1:0]     req_rdy;
  logic [N*A_W-1:0] req_a;
  logic [N*B_W-1:0] req_b;
  logic             res_vld;
  logic             res_rdy;
  logic [P_W-1:0]   res_dout;
  logic [ID_W-1:0]  res_id;
  logic             res_sat;

  modport master (
    output req_vld, req_a, req_b, res_rdy,
    input  req_rdy, res_vld, res_dout, res_id, res_sat
  );

  modport slave (
    input  req_vld, req_a, req_b, res_rdy,
    output req_rdy, res_vld, res_dout, res_id, res_sat
  );
endinterface

// File: rtl/case_2_mul_share_arb.sv
// case_2_mul_share_arb
// One signed multiplier (A_W x B_W, result reduced to P_W bits) shared by
// N requesters under round-robin arbitration. The product lands in a single
// output register one cycle after the operand handshake; the register can be
// drained and refilled in the same cycle.
// Ports:
//   ap_clk  : clock, rising edge
//   ap_rst  : synchronous active-high reset
//   bus     : case_2_mul_share_arb_if.slave (operand and result handshakes)
//   op_cnt  : results consumed downstream (wraps)
//   idle    : no result held and no requester asking
// Build option: define CASE_2_MUL_SHARE_ARB_SAT_EN to clamp the product into
// the P_W signed range and report clamping on res_sat; otherwise the product
// wraps and res_sat is tied low.
module case_2_mul_share_arb #(
  parameter int N     = 4,
  parameter int A_W   = 5,
  parameter int B_W   = 4,
  parameter int P_W   = 5,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  case_2_mul_share_arb_if.slave bus,
  output logic [CNT_W-1:0]     op_cnt,
  output logic                 idle
);

  localparam int F_W = A_W + B_W;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

  slot_t            state_reg;
  logic [P_W-1:0]   dout_reg;
  logic [ID_W-1:0]  id_reg;
  logic [ID_W-1:0]  last_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             res_vld;
  logic             accept;
  logic             grant_vld;
  logic [ID_W-1:0]  grant_idx;
  logic             xfer;
  logic             drain;

  logic [A_W-1:0]   a_arr [N];
  logic [B_W-1:0]   b_arr [N];
  logic [A_W-1:0]   a_sel;
  logic [B_W-1:0]   b_sel;
  logic signed [F_W-1:0] a_ext;
  logic signed [F_W-1:0] b_ext;
  logic signed [F_W-1:0] p_full;
  logic [P_W-1:0]   dout_next;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign a_arr[gi] = bus.req_a[gi*A_W +: A_W];
    assign b_arr[gi] = bus.req_b[gi*B_W +: B_W];
  end

  assign res_vld = (state_reg == FULL);
  assign accept  = !res_vld || bus.res_rdy;
  assign drain   = res_vld && bus.res_rdy;

  // Round-robin scan starting just after the last winner, wrapping at N.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (int'(last_reg) + k) % N;
      if (!grant_vld && bus.req_vld[j]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(j);
      end
    end
  end

  assign xfer        = accept && grant_vld && !ap_rst;
  assign bus.req_rdy = xfer ? (N'(1) << grant_idx) : '0;

  // Sign-extend both operands to the full product width so the plain
  // multiply yields the exact signed product.
  assign a_sel  = a_arr[grant_idx];
  assign b_sel  = b_arr[grant_idx];
  assign a_ext  = {{B_W{a_sel[A_W-1]}}, a_sel};
  assign b_ext  = {{A_W{b_sel[B_W-1]}}, b_sel};
  assign p_full = a_ext * b_ext;

`ifdef CASE_2_MUL_SHARE_ARB_SAT_EN
  localparam int P_MAX = (1 <<< (P_W - 1)) - 1;
  localparam int P_MIN = -(1 <<< (P_W - 1));

  logic sat_next;
  logic sat_reg;
  int   p_int;

  always_comb begin
    p_int     = int'(p_full);
    sat_next  = 1'b0;
    dout_next = p_full[P_W-1:0];
    if (p_int > P_MAX) begin
      dout_next = P_W'(P_MAX);
      sat_next  = 1'b1;
    end else if (p_int < P_MIN) begin
      dout_next = P_W'(P_MIN);
      sat_next  = 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sat_reg <= 1'b0;
    end else if (xfer) begin
      sat_reg <= sat_next;
    end
  end

  assign bus.res_sat = sat_reg;
`else
  // Upper product bits are discarded: two's-complement wrap.
  logic unused_hi;
  assign unused_hi   = ^p_full[F_W-1:P_W];
  assign dout_next   = p_full[P_W-1:0];
  assign bus.res_sat = 1'b0;
`endif

  // Output slot: a new grant always refills (even while draining); a drain
  // without a grant empties it. Data fields hold when not refilled.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_reg <= EMPTY;
      dout_reg  <= '0;
      id_reg    <= '0;
      last_reg  <= ID_W'(N - 1);
      cnt_reg   <= '0;
    end else begin
      if (drain) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (xfer) begin
        state_reg <= FULL;
        dout_reg  <= dout_next;
        id_reg    <= grant_idx;
        last_reg  <= grant_idx;
      end else if (drain) begin
        state_reg <= EMPTY;
      end
    end
  end

  assign bus.res_vld  = res_vld;
  assign bus.res_dout = dout_reg;
  assign bus.res_id   = id_reg;
  assign op_cnt       = cnt_reg;
  assign idle         = !res_vld && !(|bus.req_vld);

endmodule
